// File: rtl/pc_ir_unit_if.sv
// Purpose: bundles the PC/IR stage inputs from memory, ALU and Control with its outputs.
// Latency: wires only; adds no cycles.
// Backpressure: none; every signal is sampled or driven every cycle.
interface pc_ir_unit_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     mem_rdata;
  logic [WIDTH-1:0]     alu_result;
  logic [WIDTH-1:0]     alu_out;
  logic [WIDTH-1:0]     acc;
  logic                 PCWrite;
  logic [1:0]           PCSrc;
  logic                 IRWrite;
  logic                 BranchCycle;
  logic [1:0]           BranchCond;
  logic                 SignExt;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     ret_pc;
  logic [7:0]           opcode;
  logic [WIDTH-1:0]     imm_ext;
  logic [WIDTH-1:0]     jump_target;
  logic                 branch_taken;
  logic [CNT_WIDTH-1:0] instr_count;

  // Control/memory/ALU side: drives the inputs and observes the stage outputs.
  modport master (
    output mem_rdata, alu_result, alu_out, acc, PCWrite, PCSrc, IRWrite,
           BranchCycle, BranchCond, SignExt,
    input  pc, ret_pc, opcode, imm_ext, jump_target, branch_taken, instr_count
  );

  // PC/IR stage side.
  modport slave (
    input  mem_rdata, alu_result, alu_out, acc, PCWrite, PCSrc, IRWrite,
           BranchCycle, BranchCond, SignExt,
    output pc, ret_pc, opcode, imm_ext, jump_target, branch_taken, instr_count
  );
endinterface

// File: rtl/pc_ir_unit.sv
// Purpose: PC, IR, return-PC and retired-instruction counter of the multicycle accumulator CPU.
// Latency: registers update one edge after their enable; decode fields and branch_taken are combinational.
// Backpressure: none; Control enables are obeyed every cycle, there is no stall path.
module pc_ir_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter int               CNT_WIDTH = 16
) (
  input logic         clk,
  input logic         reset,
  pc_ir_unit_if.slave bus
);

  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     ir_q;
  logic [WIDTH-1:0]     ret_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 cond_true;
  logic                 pc_en;
  logic [WIDTH-1:0]     pc_next;
  logic [WIDTH-1:0]     jump_target;

  // Page-relative jump: upper PC bits are kept from the registered PC, so a
  // fetch that rewrites PC in the same edge does not affect the target.
  assign jump_target = {pc_q[WIDTH-1:9], ir_q[7:0], 1'b0};

  // Branch condition evaluated on the accumulator, acc treated as signed.
  always_comb begin
    cond_true = 1'b0;
    case (bus.BranchCond)
      2'b00:   cond_true = (bus.acc == '0);
      2'b01:   cond_true = (bus.acc != '0);
      2'b10:   cond_true = bus.acc[WIDTH-1];
      default: cond_true = 1'b1;
    endcase
  end

  // PC source select; a combined PCWrite + taken branch still writes once.
  always_comb begin
    pc_next = jump_target;
    case (bus.PCSrc)
      2'b00:   pc_next = jump_target;
      2'b01:   pc_next = bus.alu_result;
      2'b10:   pc_next = bus.alu_out;
      default: pc_next = bus.acc;
    endcase
  end

  assign pc_en = bus.PCWrite | (bus.BranchCycle & cond_true);

  // State update; reset discards any write enabled in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      ret_q <= RESET_PC;
      cnt_q <= '0;
    end else begin
      if (pc_en) begin
        pc_q <= pc_next;
      end
      if (bus.IRWrite) begin
        ir_q  <= bus.mem_rdata;
        ret_q <= bus.alu_result;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.ret_pc       = ret_q;
  assign bus.opcode       = ir_q[WIDTH-1:WIDTH-8];
  assign bus.imm_ext      = bus.SignExt ? {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]}
                                        : {{(WIDTH-8){1'b0}}, ir_q[7:0]};
  assign bus.jump_target  = jump_target;
  assign bus.branch_taken = bus.BranchCycle & cond_true;
  assign bus.instr_count  = cnt_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Purpose: directed scoreboard bench for pc_ir_unit.
// Latency: checks land at the falling edge after each expectation is queued.
// Backpressure: none; the monitor consumes one expectation per flagged cycle.
module tb_pc_ir_unit;

  localparam int M_PC  = 1;
  localparam int M_RET = 2;
  localparam int M_OP  = 4;
  localparam int M_IMM = 8;
  localparam int M_JT  = 16;
  localparam int M_BT  = 32;
  localparam int M_CNT = 64;

  typedef struct {
    string       name;
    int          mask;
    logic [15:0] pc;
    logic [15:0] ret;
    logic [15:0] op;
    logic [15:0] imm;
    logic [15:0] jt;
    logic [15:0] bt;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic obs_vld = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  pc_ir_unit_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();

  pc_ir_unit #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, want);
    end
  endtask

  // Monitor: on every flagged cycle pop one expectation and compare away from the rising edge.
  always @(negedge clk) begin
    if (obs_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((e.mask & M_PC)  != 0) cmp(e.name, "pc",           bus.pc,                   e.pc);
        if ((e.mask & M_RET) != 0) cmp(e.name, "ret_pc",       bus.ret_pc,               e.ret);
        if ((e.mask & M_OP)  != 0) cmp(e.name, "opcode",       {8'h00, bus.opcode},      e.op);
        if ((e.mask & M_IMM) != 0) cmp(e.name, "imm_ext",      bus.imm_ext,              e.imm);
        if ((e.mask & M_JT)  != 0) cmp(e.name, "jump_target",  bus.jump_target,          e.jt);
        if ((e.mask & M_BT)  != 0) cmp(e.name, "branch_taken", {15'h0, bus.branch_taken}, e.bt);
        if ((e.mask & M_CNT) != 0) cmp(e.name, "instr_count",  bus.instr_count,          e.cnt);
      end
    end
  end

  // Queue an expectation for the coming falling edge.
  task automatic chk(input string nm, input int mask,
                     input logic [15:0] pc, input logic [15:0] ret, input logic [15:0] op,
                     input logic [15:0] imm, input logic [15:0] jt, input logic [15:0] bt,
                     input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.mask = mask; e.pc = pc; e.ret = ret; e.op = op;
    e.imm = imm; e.jt = jt; e.bt = bt; e.cnt = cnt;
    exp_q.push_back(e);
    obs_vld = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    obs_vld = 1'b0;
  endtask

  task automatic idle();
    bus.PCWrite     = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.BranchCycle = 1'b0;
  endtask

  task automatic pcw(input logic [1:0] src);
    bus.PCSrc   = src;
    bus.PCWrite = 1'b1;
  endtask

  task automatic br(input logic [1:0] cond, input logic [15:0] a, input logic [15:0] tgt);
    bus.BranchCycle = 1'b1;
    bus.BranchCond  = cond;
    bus.acc         = a;
    bus.alu_out     = tgt;
    bus.PCSrc       = 2'b10;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.mem_rdata  = 16'h0;
    bus.alu_result = 16'h0;
    bus.alu_out    = 16'h0;
    bus.acc        = 16'h0;
    bus.PCSrc      = 2'b00;
    bus.BranchCond = 2'b00;
    bus.SignExt    = 1'b0;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    chk("reset", M_PC | M_RET | M_OP | M_CNT, 16'h0000, 16'h0000, 16'h00, 0, 0, 0, 16'h0000);
    cyc();

    // Fetch: IR gets the word at the old PC while PC advances in the same edge.
    bus.mem_rdata = 16'h0805; bus.alu_result = 16'h0002; bus.IRWrite = 1'b1; pcw(2'b01);
    chk("fetch_pre", M_PC | M_JT, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    cyc();
    idle();
    chk("fetch1", M_PC | M_RET | M_OP | M_CNT, 16'h0002, 16'h0002, 16'h08, 0, 0, 0, 16'h0001);
    cyc();

    bus.mem_rdata = 16'h0DF3; bus.alu_result = 16'h0202; bus.IRWrite = 1'b1; pcw(2'b01);
    cyc();
    idle();
    bus.SignExt = 1'b1;
    chk("imm_sext", M_PC | M_OP | M_IMM | M_JT | M_CNT, 16'h0202, 0, 16'h0D, 16'hFFF3, 16'h03E6, 0, 16'h0002);
    cyc();
    bus.SignExt = 1'b0;
    chk("imm_zext", M_IMM, 0, 0, 0, 16'h00F3, 0, 0, 0);
    cyc();
    pcw(2'b00);
    cyc();
    idle();
    chk("jump", M_PC, 16'h03E6, 0, 0, 0, 0, 0, 0);
    cyc();

    // Conditional branches.
    br(2'b00, 16'h0000, 16'h0040);
    chk("beqz_taken", M_BT, 0, 0, 0, 0, 0, 16'h1, 0);
    cyc();
    idle();
    chk("beqz_pc", M_PC, 16'h0040, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b00, 16'h0005, 16'h0080);
    chk("beqz_not", M_BT, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc();
    idle();
    chk("beqz_hold", M_PC, 16'h0040, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b10, 16'h8001, 16'h0100);
    chk("bneg_taken", M_BT, 0, 0, 0, 0, 0, 16'h1, 0);
    cyc();
    idle();
    chk("bneg_pc", M_PC, 16'h0100, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b00, 16'h8001, 16'h0200);
    chk("beqz_neg", M_BT, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc();
    idle();
    chk("beqz_neg_pc", M_PC, 16'h0100, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b01, 16'h0003, 16'h0300);
    chk("bnez_taken", M_BT, 0, 0, 0, 0, 0, 16'h1, 0);
    cyc();
    idle();
    chk("bnez_pc", M_PC, 16'h0300, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b11, 16'h0000, 16'h0400);
    chk("balw_zero", M_BT, 0, 0, 0, 0, 0, 16'h1, 0);
    cyc();
    br(2'b11, 16'hFFFF, 16'h0500);
    chk("balw_neg", M_BT | M_PC, 16'h0400, 0, 0, 0, 0, 16'h1, 0);
    cyc();
    idle();
    chk("balw_pc", M_PC, 16'h0500, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b11, 16'h0000, 16'h0600);
    bus.BranchCycle = 1'b0;
    chk("nobranch", M_BT, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc();
    chk("nobranch_pc", M_PC, 16'h0500, 0, 0, 0, 0, 0, 0);
    cyc();
    br(2'b11, 16'h0000, 16'h0700);
    pcw(2'b10);
    cyc();
    idle();
    chk("pcw_and_br", M_PC, 16'h0700, 0, 0, 0, 0, 0, 0);
    cyc();

    // Jump-register and PC wrap.
    bus.acc = 16'h1234; pcw(2'b11);
    cyc();
    idle();
    chk("jr", M_PC, 16'h1234, 0, 0, 0, 0, 0, 0);
    cyc();
    bus.acc = 16'hFFFE; pcw(2'b11);
    cyc();
    bus.alu_result = 16'h0000; pcw(2'b01);
    chk("pre_wrap", M_PC, 16'hFFFE, 0, 0, 0, 0, 0, 0);
    cyc();
    idle();
    chk("wrap", M_PC | M_RET | M_OP | M_CNT, 16'h0000, 16'h0202, 16'h0D, 0, 0, 0, 16'h0002);
    cyc();

    // Reset overrides a fetch in the same cycle.
    bus.acc = 16'h5555; pcw(2'b11);
    cyc();
    reset = 1'b1;
    bus.mem_rdata = 16'hABCD; bus.alu_result = 16'h1111; bus.IRWrite = 1'b1; pcw(2'b01);
    cyc();
    reset = 1'b0;
    idle();
    chk("reset_mid", M_PC | M_RET | M_OP | M_CNT, 16'h0000, 16'h0000, 16'h00, 0, 0, 0, 16'h0000);
    cyc();

    // Counter wrap after 0xFFFF fetches.
    bus.mem_rdata = 16'h4200;
    bus.IRWrite = 1'b1;
    for (int i = 0; i < 16'hFFFF; i++) cyc();
    idle();
    chk("cnt_max", M_CNT | M_OP, 0, 0, 16'h42, 0, 0, 0, 16'hFFFF);
    cyc();
    bus.IRWrite = 1'b1;
    cyc();
    idle();
    chk("cnt_wrap", M_CNT, 0, 0, 0, 0, 0, 0, 16'h0000);
    cyc();
    cyc();

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Program-counter and instruction-register stage of the multicycle accumulator processor.
- Holds PC, IR and a latched return PC, and feeds `opcode` / immediate fields to `Control`.
- Consumes `Control`'s PCWrite, PCSrc, IRWrite, BranchCycle, BranchCond and SignExt.
- Evaluates the branch condition against accumulator status and counts retired instructions for debug.

Parameters:
- WIDTH, 16, datapath / PC / instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_rdata  input  WIDTH  instruction word from memory for the current PC.
- alu_result  input  WIDTH  combinational ALU output (PC+2 during fetch).
- alu_out  input  WIDTH  registered ALUOut (branch target computed in decode).
- acc  input  WIDTH  current accumulator value, used for branch conditions.
- PCWrite  input  1  unconditional PC write enable from `Control`.
- PCSrc  input  2  PC source select.
- IRWrite  input  1  latch instruction and fetch PC.
- BranchCycle  input  1  conditional PC write enable.
- BranchCond  input  2  condition select.
- SignExt  input  1  1 = sign-extend immediate, 0 = zero-extend.
- pc  output  WIDTH  current PC.
- ret_pc  output  WIDTH  PC+2 of the instruction in IR; used by jal as the data written to memory.
- opcode  output  8  IR[15:8], to `Control`.
- imm_ext  output  WIDTH  IR[7:0] extended per SignExt.
- jump_target  output  WIDTH  {pc[15:9], IR[7:0], 1'b0}.
- branch_taken  output  1  combinational: BranchCycle & cond_true.
- instr_count  output  CNT_WIDTH  number of IRWrite cycles since reset.

Behaviour:
- Reset (synchronous, evaluated at the clock edge):
  - pc = RESET_PC; IR = 0, so opcode = 0; ret_pc = RESET_PC; instr_count = 0.
  - Reset overrides every enable in the same cycle.
- IR: on IRWrite, IR <= mem_rdata, and in the same edge ret_pc <= alu_result (PC+2). IR and ret_pc hold otherwise.
- PC next-value mux:
  - PCSrc 00 → jump_target.
  - PCSrc 01 → alu_result.
  - PCSrc 10 → alu_out.
  - PCSrc 11 → acc (jump-register).
- PC enable: pc_en = PCWrite | (BranchCycle & cond_true). When pc_en = 1, pc <= selected mux value.
- Condition select (cond_true, from acc as signed):
  - 00 → acc == 0.
  - 01 → acc != 0.
  - 10 → acc[WIDTH-1] == 1 (negative).
  - 11 → always true.
- branch_taken is combinational and depends only on BranchCycle, BranchCond and acc. It is 0 whenever BranchCycle = 0.
- Simultaneous IRWrite and PCWrite (fetch cycle):
  - IR captures mem_rdata for the old PC.
  - PC takes the new value.
  - jump_target is computed from the *registered* pc/IR, never from the new values.
- imm_ext: SignExt = 1 → {{8{IR[7]}}, IR[7:0]}; SignExt = 0 → {8'h00, IR[7:0]}. Combinational.
- instr_count increments by 1 on every IRWrite edge and wraps from all-ones to 0 without a flag.
- PCWrite and BranchCycle both high: the PC is written once from the PCSrc selection; there is no double update.
- PC increments wrap modulo 2^WIDTH; no overflow detection.
- Reset asserted mid-instruction: any pending write is discarded and the next cycle begins fetch from RESET_PC.
- Latency:
  - pc, IR, ret_pc and instr_count update one edge after their enable is sampled.
  - opcode is valid the cycle after IRWrite, i.e. during decode.

Test Plan:
- Reset → pc = 0x0000, opcode = 0, instr_count = 0. Then one cycle with IRWrite = 1, PCWrite = 1, PCSrc = 01, mem_rdata = 0x0805, alu_result = 0x0002 → opcode = 0x08, pc = 0x0002, ret_pc = 0x0002, instr_count = 1.
- With IR = 0x0DF3, SignExt = 1 → imm_ext = 0xFFF3; with SignExt = 0 → imm_ext = 0x00F3. With pc = 0x0202, PCSrc = 00, PCWrite = 1 → pc = 0x03E6.
- Branch: BranchCycle = 1, BranchCond = 00, alu_out = 0x0040, PCSrc = 10.
  - acc = 0 → branch_taken = 1, pc = 0x0040.
  - Repeated with acc = 5 → branch_taken = 0, pc unchanged.
- BranchCond sweep:
  - acc = 0x8001: cond 10 taken, cond 00 not taken.
  - acc = 0x0003: cond 01 taken.
  - cond 11 taken for any acc.
  - BranchCycle = 0 never updates pc.
- Jump-register: acc = 0x1234, PCSrc = 11, PCWrite = 1 → pc = 0x1234. Also, with pc = 0xFFFE, PCSrc = 01 and alu_result = 0x0000 → pc wraps to 0x0000.
- Reset asserted during a cycle with IRWrite = 1 and PCWrite = 1 → pc = RESET_PC, IR = 0 and instr_count = 0. After 0xFFFF IRWrite pulses (CNT_WIDTH = 16), the next pulse wraps instr_count to 0.
